// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack handshake and holds one instruction for the core.
// Optional feature: define FETCH_TIMEOUT_EN to fault on a request left unacknowledged for TIMEOUT cycles.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruct,
    output logic        instruct_valid,
    input  logic        advance,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2,
        FAULT = 2'd3
    } state_t;

    // Reject illegal parameter values at elaboration time.
    if ((TIMEOUT < 2) || (RESET_PC[1:0] != 2'b00)) begin : g_bad_param
        $error("fetch_unit: TIMEOUT must be >= 2 and RESET_PC word-aligned");
    end

    function automatic logic [31:0] select_next_pc(
        input logic        jmp,
        input logic [31:0] jmp_tgt,
        input logic        br,
        input logic [31:0] br_tgt,
        input logic [31:0] seq
    );
        logic [31:0] nxt;
        if (jmp) begin
            nxt = jmp_tgt;
        end else if (br) begin
            nxt = br_tgt;
        end else begin
            nxt = seq;
        end
        return nxt;
    endfunction

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

    state_t      state_r;
    state_t      state_s;
    logic [31:0] pc_r;
    logic [31:0] pc_s;
    logic [31:0] pc_plus4_r;
    logic [31:0] instruct_r;
    logic [31:0] instruct_s;
    logic [31:0] next_pc_s;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
`endif

    // Next-state, next-PC and instruction latch selection.
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        instruct_s = instruct_r;
        next_pc_s  = select_next_pc(jump, jump_target, branch_taken, branch_target, pc_plus4_r);
`ifdef FETCH_TIMEOUT_EN
        cnt_s      = cnt_r;
`endif
        case (state_r)
            IDLE: begin
                state_s = FETCH;
`ifdef FETCH_TIMEOUT_EN
                cnt_s   = {CNT_W{1'b0}};
`endif
            end
            FETCH: begin
                if (imem_ack) begin
                    instruct_s = imem_rdata;
                    state_s    = VALID;
                end else begin
`ifdef FETCH_TIMEOUT_EN
                    // An ack on the last allowed cycle takes the branch above and wins.
                    if (cnt_r == CNT_LAST) begin
                        state_s = FAULT;
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
`else
                    state_s = FETCH;
`endif
                end
            end
            VALID: begin
                if (advance) begin
                    // The PC takes the new address even when it is misaligned.
                    pc_s = next_pc_s;
                    if (is_misaligned(next_pc_s)) begin
                        state_s = FAULT;
                    end else begin
                        state_s = FETCH;
`ifdef FETCH_TIMEOUT_EN
                        cnt_s   = {CNT_W{1'b0}};
`endif
                    end
                end else begin
                    state_s = VALID;
                end
            end
            FAULT: begin
                state_s = FAULT;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, PC and instruction registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            pc_r       <= RESET_PC;
            pc_plus4_r <= RESET_PC + 32'd4;
            instruct_r <= 32'h0000_0000;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            pc_plus4_r <= pc_s + 32'd4;
            instruct_r <= instruct_s;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    // Unacknowledged-request cycle counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_s;
        end
    end
`endif

    assign imem_req       = (state_r == FETCH);
    assign imem_addr      = pc_r;
    assign instruct       = instruct_r;
    assign instruct_valid = (state_r == VALID);
    assign pc             = pc_r;
    assign pc_plus4       = pc_plus4_r;
    assign fetch_fault    = (state_r == FAULT);

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage feeding the single-cycle `cpu` core. Owns the program counter, issues requests to a variable-latency instruction memory through a req/ack handshake, and presents one instruction at a time on `instruct` until the core signals consumption. On consumption it selects the next PC from the core's jump, branch and sequential controls, replacing the PC register and next-PC muxing in the core.

## Interface
- `RESET_PC`, 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `TIMEOUT`, 16: max consecutive unacknowledged request cycles, ≥2. Used only with `FETCH_TIMEOUT_EN`.

- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch byte address; stable while `imem_req`=1.
- `imem_ack` in 1: read data valid this cycle.
- `imem_rdata` in 32: instruction word.
- `instruct` out 32: current instruction to the core.
- `instruct_valid` out 1: `instruct` holds a fetched instruction.
- `advance` in 1: core has consumed `instruct`.
- `branch_taken` in 1: branch & zero from the core.
- `branch_target` in 32: branch target address.
- `jump` in 1: jump select from the control unit.
- `jump_target` in 32: jump target address.
- `pc` out 32: address of `instruct`.
- `pc_plus4` out 32: `pc`+4, modulo 2^32.
- `fetch_fault` out 1: sticky fault flag.

## Operation
- FSM states: IDLE, FETCH, VALID, FAULT. Reset state is IDLE.
- IDLE: lasts one cycle, then moves to FETCH. Outputs `imem_req`=0.
- FETCH: `imem_req`=1 and `imem_addr`=`pc`.
  - On `imem_ack`=1, `instruct` latches `imem_rdata` and the FSM moves to VALID.
  - Otherwise the FSM stays in FETCH and holds the request.
- VALID: `instruct_valid`=1; `instruct` and `pc` are held.
  - On `advance`=1, next PC = `jump` ? `jump_target` : `branch_taken` ? `branch_target` : `pc_plus4`. Jump has priority over branch.
  - The FSM then moves to FETCH, or to FAULT if next PC[1:0]≠0. On a misalignment fault, `pc` still updates to the bad address.
- FAULT: `imem_req`=0, `instruct_valid`=0, `fetch_fault`=1. Only `rst` exits this state.
- `advance`, `branch_taken`, `jump` and the targets are ignored outside VALID.
- `imem_ack` and `imem_rdata` are ignored outside FETCH.
- `pc` wraps: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no fault.
- Reset values:
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `instruct`=0, `instruct_valid`=0.
  - `pc`=`RESET_PC`, `pc_plus4`=`RESET_PC`+4.
  - `fetch_fault`=0.
- Reset asserted mid-operation, including mid-request, returns the FSM to IDLE immediately. An `imem_ack` arriving after reset is ignored.

## Timing
- `imem_req`, `imem_addr` and `instruct_valid` are decoded from registered state; there is no combinational path from inputs to outputs.
- `rst` deasserted before edge 0: IDLE during cycle 0, `imem_req`=1 from cycle 1.
- `imem_ack` in cycle N yields `instruct_valid`=1 and new `instruct` from cycle N+1.
- `advance` in cycle M yields `instruct_valid`=0, new `pc`, and `imem_req`=1 at the new address in cycle M+1.
- Zero-wait memory gives 2 cycles per instruction. Each wait state adds one cycle.
- Timeout counter (with `FETCH_TIMEOUT_EN`):
  - Clears on entry to FETCH; increments each FETCH cycle without ack.
  - No ack while counter = `TIMEOUT`-1 sends the FSM to FAULT next cycle.
  - An ack on that same cycle wins and is accepted normally.

## Configuration
- `FETCH_TIMEOUT_EN` defined: timeout counter and timeout fault are present, as described above.
- `FETCH_TIMEOUT_EN` undefined: no counter, FETCH waits indefinitely for `imem_ack`, and `fetch_fault` is raised only by misalignment. `TIMEOUT` is unused.

## Test plan
- Reset release, `RESET_PC`=0, ack in the first request cycle with rdata 32'h2008_0005 -> `imem_addr`=0 in cycle 1; `instruct`=32'h2008_0005 and `instruct_valid`=1 in cycle 2; `pc_plus4`=4.
- Three sequential advances, ack latency 3 cycles -> addresses 0, 4, 8, 12, each held stable while `imem_req`=1; `instruct_valid` low between instructions.
- `advance` with `jump`=1, `jump_target`=32'h0040_0020 and `branch_taken`=1, `branch_target`=32'h10 -> next `imem_addr`=32'h0040_0020. Same with `jump`=0 -> 32'h10.
- Branch to 32'h0000_0006 -> FAULT next cycle: `fetch_fault`=1, `imem_req`=0, `pc`=6. Stays there until `rst` pulse restores all reset values.
- `pc`=32'hFFFF_FFFC, advance with no branch or jump -> `imem_addr`=0, no fault.
- `FETCH_TIMEOUT_EN` with `TIMEOUT`=4, ack withheld -> `fetch_fault`=1 after the 4th request cycle. Ack on the 4th cycle -> accepted, no fault. Async `rst` during wait -> `imem_req`=0 immediately.
